// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for a 6-bit Fibonacci LFSR datapath on the DE1 board.
// It turns debounced keys into advance/load strobes, measures the sequence period and traps the all-zero state.
module lfsr_seq_ctrl #(
  parameter int W        = 6,
  parameter int DEB_CYC  = 500000,
  parameter int BASE_DIV = 5000000
) (
  input  logic         CLOCK_50,
  input  logic [3:0]   KEY,
  input  logic [9:0]   SW,
  input  logic [W-1:0] lfsr_q,
  output logic         lfsr_en,
  output logic         lfsr_load,
  output logic [W-1:0] lfsr_seed,
  output logic [W-1:0] step_cnt,
  output logic [W-1:0] period,
  output logic         period_vld,
  output logic         running,
  output logic         lockup
);

  localparam int DC_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int PRE_W = $clog2(4 * BASE_DIV);
  localparam logic [W-1:0] SEED_ONE = W'(1);
  localparam logic [DC_W-1:0] DEB_LAST = DC_W'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    IDLE   = 2'd1,
    RUN    = 2'd2,
    LOCKED = 2'd3
  } state_t;

  logic clk;
  assign clk = CLOCK_50;

  // Reset key is only synchronised, never debounced, so a single low cycle is honoured.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk) begin
    rst_sync_reg <= {rst_sync_reg[0], KEY[3]};
  end

  assign rst_n = rst_sync_reg[1];

  // One debouncer per control key: 0 = step, 1 = run/stop, 2 = load.
  logic [2:0] press;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic            s1_reg;
      logic            s2_reg;
      logic            lvl_reg;
      logic            press_reg;
      logic [DC_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_reg    <= 1'b1;
          s2_reg    <= 1'b1;
          lvl_reg   <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= KEY[gi];
          s2_reg    <= s1_reg;
          press_reg <= 1'b0;
          if (s2_reg == lvl_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            lvl_reg   <= s2_reg;
            cnt_reg   <= '0;
            press_reg <= ~s2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic step_press;
  logic run_press;
  logic load_press;

  assign step_press = press[0];
  assign run_press  = press[1];
  assign load_press = press[2];

  logic [W-1:0] sw_seed;
  logic [W-1:0] seed_fix;
  logic         unused_sw;

  assign sw_seed   = SW[W-1:0];
  assign seed_fix  = (sw_seed == '0) ? SEED_ONE : sw_seed;
  assign unused_sw = ^SW[7:6];

  state_t           state_reg;
  logic [1:0]       rate_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic [PRE_W-1:0] pre_lim;
  logic             chk_reg;
  logic             lock_seen;

  assign pre_lim = PRE_W'(BASE_DIV * (int'(rate_reg) + 1) - 1);

  // A zero state only counts when the datapath is not being loaded or advanced this cycle.
  assign lock_seen = !lfsr_load && !lfsr_en && (lfsr_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      lfsr_en     <= 1'b0;
      lfsr_load   <= 1'b0;
      lfsr_seed   <= SEED_ONE;
      step_cnt    <= '0;
      period      <= '0;
      period_vld  <= 1'b0;
      running     <= 1'b0;
      lockup      <= 1'b0;
      rate_reg    <= 2'd0;
      pre_cnt_reg <= '0;
      chk_reg     <= 1'b0;
    end else begin
      lfsr_en   <= 1'b0;
      lfsr_load <= 1'b0;
      chk_reg   <= lfsr_en;

      if (lfsr_en) begin
        step_cnt <= step_cnt + 1'b1;
      end

      // step_cnt already includes the advance that produced this lfsr_q.
      if (chk_reg && !period_vld && (lfsr_q == lfsr_seed)) begin
        period     <= step_cnt;
        period_vld <= 1'b1;
      end

      if (load_press) begin
        lfsr_seed <= seed_fix;
        running   <= 1'b0;
        state_reg <= LOAD;
      end else begin
        case (state_reg)
          LOAD: begin
            lfsr_load  <= 1'b1;
            step_cnt   <= '0;
            period_vld <= 1'b0;
            lockup     <= 1'b0;
            state_reg  <= IDLE;
          end
          IDLE: begin
            if (lock_seen) begin
              lockup    <= 1'b1;
              running   <= 1'b0;
              state_reg <= LOCKED;
            end else if (run_press) begin
              running     <= 1'b1;
              pre_cnt_reg <= '0;
              rate_reg    <= SW[9:8];
              state_reg   <= RUN;
            end else if (step_press) begin
              lfsr_en <= 1'b1;
            end
          end
          RUN: begin
            if (lock_seen) begin
              lockup    <= 1'b1;
              running   <= 1'b0;
              state_reg <= LOCKED;
            end else if (run_press) begin
              running   <= 1'b0;
              state_reg <= IDLE;
            end else if (pre_cnt_reg == pre_lim) begin
              lfsr_en     <= 1'b1;
              pre_cnt_reg <= '0;
              rate_reg    <= SW[9:8];
            end else begin
              pre_cnt_reg <= pre_cnt_reg + 1'b1;
            end
          end
          LOCKED: begin
            running <= 1'b0;
          end
          default: begin
            state_reg <= LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: hosts a behavioural LFSR datapath and checks strobes, counters,
// period and lock-up against a reference model built from the sequence definition.
module tb_lfsr_seq_ctrl;

  localparam int W    = 6;
  localparam int DEB  = 4;
  localparam int BDIV = 8;

  logic         clk = 1'b0;
  logic [3:0]   key;
  logic [9:0]   sw;
  logic [W-1:0] lfsr_q = '0;
  logic         force_zero = 1'b0;
  logic         lfsr_en, lfsr_load, period_vld, running, lockup;
  logic [W-1:0] lfsr_seed, step_cnt, period;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int en_cnt = 0, load_cnt = 0, en_wide = 0, load_wide = 0;
  logic en_prev = 1'b0, load_prev = 1'b0;
  logic [W-1:0] load_seed_seen = '0;
  int en_q[$];

  logic [W-1:0] m_seed;
  int           m_steps;

  always #10 clk = ~clk;

  lfsr_seq_ctrl #(.W(W), .DEB_CYC(DEB), .BASE_DIV(BDIV)) dut (
    .CLOCK_50  (clk),
    .KEY       (key),
    .SW        (sw),
    .lfsr_q    (lfsr_q),
    .lfsr_en   (lfsr_en),
    .lfsr_load (lfsr_load),
    .lfsr_seed (lfsr_seed),
    .step_cnt  (step_cnt),
    .period    (period),
    .period_vld(period_vld),
    .running   (running),
    .lockup    (lockup)
  );

  // Datapath stand-in: x^6+x^5+1 Fibonacci register, with a hook to force it to zero.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (force_zero) lfsr_q <= '0;
    else if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_en) lfsr_q <= {lfsr_q[W-2:0], lfsr_q[W-1] ^ lfsr_q[W-2]};
  end

  always @(negedge clk) begin
    if (lfsr_en) begin
      en_cnt++;
      en_q.push_back(cyc);
      if (en_prev) en_wide++;
    end
    if (lfsr_load) begin
      load_cnt++;
      load_seed_seen = lfsr_seed;
      if (load_prev) load_wide++;
    end
    en_prev   = lfsr_en;
    load_prev = lfsr_load;
  end

  function automatic logic [W-1:0] ref_adv(input logic [W-1:0] s);
    return {s[W-2:0], s[W-1] ^ s[W-2]};
  endfunction

  // First return to the seed within n advances, 0 if none yet.
  function automatic int ref_period(input logic [W-1:0] seed, input int n);
    logic [W-1:0] s;
    s = seed;
    for (int k = 1; k <= n; k++) begin
      s = ref_adv(s);
      if (s == seed) return k;
    end
    return 0;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_key(input int k, input int hold);
    key[k] = 1'b0;
    ticks(hold);
    key[k] = 1'b1;
    ticks(hold);
    $display("press key%0d: en_cnt=%0d step_cnt=%0d running=%0d lockup=%0d", k, en_cnt, step_cnt, running, lockup);
  endtask

  task automatic do_load(input logic [5:0] s);
    sw[5:0] = s;
    press_key(2, 10);
    m_seed  = (s == 6'd0) ? W'(1) : s;
    m_steps = 0;
  endtask

  task automatic test_reset();
    int t;
    key = 4'b0111;
    sw  = 10'h001;
    ticks(5);
    n_cmp++; if ({lfsr_en, lfsr_load, running, lockup, period_vld} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {lfsr_en, lfsr_load, running, lockup, period_vld}); end
    n_cmp++; if (lfsr_seed !== 6'h01) begin n_fail++; $display("FAIL reset_seed: got %h want 01", lfsr_seed); end
    n_cmp++; if ({step_cnt, period} !== 12'h000) begin n_fail++; $display("FAIL reset_counts: step_cnt=%0d period=%0d want 0/0", step_cnt, period); end
    key[3] = 1'b1;
    t = 0;
    while (lfsr_load !== 1'b1 && t < 10) begin tick(); t++; end
    n_cmp++; if (lfsr_load !== 1'b1) begin n_fail++; $display("FAIL reset_load_pulse: no lfsr_load within 10 cycles"); end
    n_cmp++; if (lfsr_seed !== 6'h01) begin n_fail++; $display("FAIL reset_load_seed: got %h want 01", lfsr_seed); end
    tick();
    n_cmp++; if (lfsr_load !== 1'b0) begin n_fail++; $display("FAIL reset_load_width: lfsr_load still %b want 0", lfsr_load); end
    n_cmp++; if ({running, step_cnt} !== 7'd0) begin n_fail++; $display("FAIL reset_idle: running=%b step_cnt=%0d want 0/0", running, step_cnt); end
    m_seed  = W'(1);
    m_steps = 0;
  endtask

  task automatic step_run(input int n);
    int e0, p;
    for (int i = 0; i < n; i++) begin
      e0 = en_cnt;
      press_key(0, 10);
      m_steps++;
      p = ref_period(m_seed, m_steps);
      n_cmp++; if (en_cnt - e0 !== 1) begin n_fail++; $display("FAIL step_en_count: got %0d pulses want 1", en_cnt - e0); end
      n_cmp++; if (step_cnt !== W'(m_steps % (1 << W))) begin n_fail++; $display("FAIL step_cnt: got %0d want %0d", step_cnt, m_steps % (1 << W)); end
      n_cmp++; if (period_vld !== (p != 0)) begin n_fail++; $display("FAIL period_vld: got %b want %b after %0d steps", period_vld, p != 0, m_steps); end
      if (p != 0) begin
        n_cmp++; if (period !== W'(p)) begin n_fail++; $display("FAIL period: got %0d want %0d", period, p); end
      end
    end
  endtask

  task automatic test_step_period();
    int l0;
    l0 = load_cnt;
    do_load(6'h01);
    n_cmp++; if (load_cnt - l0 !== 1) begin n_fail++; $display("FAIL load_count: got %0d want 1", load_cnt - l0); end
    n_cmp++; if (load_seed_seen !== 6'h01) begin n_fail++; $display("FAIL load_seed: got %h want 01", load_seed_seen); end
    step_run(64);
  endtask

  task automatic test_random_steps();
    logic [5:0] s;
    int n;
    for (int it = 0; it < 3; it++) begin
      s = 6'($urandom_range(0, 63));
      n = (it == 2) ? $urandom_range(63, 70) : $urandom_range(1, 40);
      do_load(s);
      n_cmp++; if (load_seed_seen !== m_seed) begin n_fail++; $display("FAIL rand_load_seed: got %h want %h", load_seed_seen, m_seed); end
      n_cmp++; if ({period_vld, step_cnt} !== 7'd0) begin n_fail++; $display("FAIL rand_load_clear: vld=%b step_cnt=%0d want 0/0", period_vld, step_cnt); end
      step_run(n);
    end
  endtask

  task automatic test_run();
    int t, e0;
    do_load(6'h05);
    sw[9:8] = 2'b10;
    en_q.delete();
    press_key(1, 10);
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_start: running=%b want 1", running); end
    t = 0;
    while (en_q.size() < 4 && t < 300) begin tick(); t++; end
    n_cmp++;
    if (en_q.size() < 4) begin n_fail++; $display("FAIL run_ticks: %0d pulses want 4", en_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (en_q[i+1] - en_q[i] !== 24) begin n_fail++; $display("FAIL run_interval: got %0d want 24", en_q[i+1] - en_q[i]); end
    end
    en_q.delete();
    press_key(0, 10);
    press_key(0, 10);
    t = 0;
    while (en_q.size() < 4 && t < 300) begin tick(); t++; end
    n_cmp++;
    if (en_q.size() < 4) begin n_fail++; $display("FAIL run_step_ticks: %0d pulses want 4", en_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (en_q[i+1] - en_q[i] !== 24) begin n_fail++; $display("FAIL run_step_ignored: interval %0d want 24", en_q[i+1] - en_q[i]); end
    end
    press_key(1, 10);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL run_stop: running=%b want 0", running); end
    e0 = en_cnt;
    ticks(80);
    n_cmp++; if (en_cnt !== e0) begin n_fail++; $display("FAIL run_stop_en: %0d pulses after stop want 0", en_cnt - e0); end
  endtask

  task automatic test_run_rate();
    int t, r0, r1;
    r0 = $urandom_range(0, 3);
    r1 = (r0 + 1 + $urandom_range(0, 2)) % 4;
    do_load(6'($urandom_range(1, 63)));
    sw[9:8] = 2'(r0);
    en_q.delete();
    key[1] = 1'b0;
    t = 0;
    while (en_q.size() < 1 && t < 200) begin tick(); t++; if (t == 10) key[1] = 1'b1; end
    sw[9:8] = 2'(r1);
    while (en_q.size() < 3 && t < 400) begin tick(); t++; if (t == 10) key[1] = 1'b1; end
    key[1] = 1'b1;
    n_cmp++;
    if (en_q.size() < 3) begin n_fail++; $display("FAIL rate_ticks: %0d pulses want 3", en_q.size()); end
    else begin
      n_cmp++; if (en_q[1] - en_q[0] !== BDIV * (r0 + 1)) begin n_fail++; $display("FAIL rate_old: interval %0d want %0d", en_q[1] - en_q[0], BDIV * (r0 + 1)); end
      n_cmp++; if (en_q[2] - en_q[1] !== BDIV * (r1 + 1)) begin n_fail++; $display("FAIL rate_new: interval %0d want %0d", en_q[2] - en_q[1], BDIV * (r1 + 1)); end
    end
    ticks(10);
    press_key(1, 10);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL rate_stop: running=%b want 0", running); end
  endtask

  task automatic test_lockup();
    int e0;
    do_load(6'h00);
    n_cmp++; if (load_seed_seen !== 6'h01) begin n_fail++; $display("FAIL zero_seed: loaded %h want 01", load_seed_seen); end
    n_cmp++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL lock_false: lockup=%b want 0", lockup); end
    force_zero = 1'b1;
    tick();
    force_zero = 1'b0;
    ticks(3);
    n_cmp++; if ({lockup, running} !== 2'b10) begin n_fail++; $display("FAIL lock_idle: lockup/running=%b want 10", {lockup, running}); end
    e0 = en_cnt;
    press_key(0, 10);
    press_key(1, 10);
    n_cmp++; if (en_cnt !== e0) begin n_fail++; $display("FAIL lock_no_en: %0d pulses want 0", en_cnt - e0); end
    n_cmp++; if ({lockup, running} !== 2'b10) begin n_fail++; $display("FAIL lock_hold: lockup/running=%b want 10", {lockup, running}); end
    do_load(6'($urandom_range(1, 63)));
    n_cmp++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL lock_clear: lockup=%b want 0", lockup); end
    n_cmp++; if (lfsr_seed !== m_seed) begin n_fail++; $display("FAIL lock_reseed: got %h want %h", lfsr_seed, m_seed); end
  endtask

  task automatic test_lockup_run();
    int t, e0;
    sw[9:8] = 2'b00;
    en_q.delete();
    press_key(1, 10);
    t = 0;
    while (en_q.size() < 1 && t < 100) begin tick(); t++; end
    force_zero = 1'b1;
    tick();
    force_zero = 1'b0;
    ticks(3);
    n_cmp++; if ({lockup, running} !== 2'b10) begin n_fail++; $display("FAIL lock_run: lockup/running=%b want 10", {lockup, running}); end
    e0 = en_cnt;
    ticks(40);
    n_cmp++; if (en_cnt !== e0) begin n_fail++; $display("FAIL lock_run_en: %0d pulses want 0", en_cnt - e0); end
    do_load(6'h2a);
    n_cmp++; if ({lockup, running} !== 2'b00) begin n_fail++; $display("FAIL lock_run_clear: lockup/running=%b want 00", {lockup, running}); end
  endtask

  task automatic test_glitch_and_simul();
    int e0, gl;
    for (int i = 0; i < 3; i++) begin
      gl = $urandom_range(1, DEB - 1);
      e0 = en_cnt;
      key[0] = 1'b0;
      ticks(gl);
      key[0] = 1'b1;
      ticks(15);
      n_cmp++; if (en_cnt !== e0) begin n_fail++; $display("FAIL glitch: %0d-cycle glitch gave %0d pulses want 0", gl, en_cnt - e0); end
    end
    sw[9:8] = 2'b11;
    e0 = en_cnt;
    key[1:0] = 2'b00;
    ticks(10);
    key[1:0] = 2'b11;
    ticks(10);
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL simul_run: running=%b want 1", running); end
    n_cmp++; if (en_cnt !== e0) begin n_fail++; $display("FAIL simul_step_dropped: %0d pulses want 0", en_cnt - e0); end
    press_key(1, 10);
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL simul_stop: running=%b want 0", running); end
  endtask

  task automatic test_back_to_back();
    int e0;
    do_load(6'($urandom_range(1, 63)));
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) press_key(0, DEB + 2);
    m_steps = 5;
    n_cmp++; if (en_cnt - e0 !== 5) begin n_fail++; $display("FAIL b2b_en: got %0d pulses want 5", en_cnt - e0); end
    n_cmp++; if (step_cnt !== W'(m_steps)) begin n_fail++; $display("FAIL b2b_step_cnt: got %0d want %0d", step_cnt, m_steps); end
    n_cmp++; if (en_wide !== 0) begin n_fail++; $display("FAIL en_width: %0d multi-cycle lfsr_en want 0", en_wide); end
    n_cmp++; if (load_wide !== 0) begin n_fail++; $display("FAIL load_width: %0d multi-cycle lfsr_load want 0", load_wide); end
  endtask

  task automatic test_reset_mid_run();
    int t;
    do_load(6'($urandom_range(1, 63)));
    sw[9:8] = 2'b00;
    press_key(1, 10);
    ticks(20);
    n_cmp++; if (running !== 1'b1 || step_cnt == '0) begin n_fail++; $display("FAIL mid_pre: running=%b step_cnt=%0d want 1/nonzero", running, step_cnt); end
    key[3] = 1'b0;
    tick();
    key[3] = 1'b1;
    t = 0;
    while (running !== 1'b0 && t < 8) begin tick(); t++; end
    n_cmp++; if ({lfsr_en, lfsr_load, running, lockup, period_vld} !== 5'b0) begin n_fail++; $display("FAIL mid_flags: got %b want 00000", {lfsr_en, lfsr_load, running, lockup, period_vld}); end
    n_cmp++; if ({lfsr_seed, step_cnt, period} !== {6'h01, 12'h000}) begin n_fail++; $display("FAIL mid_values: seed=%h step=%0d period=%0d want 01/0/0", lfsr_seed, step_cnt, period); end
    t = 0;
    while (lfsr_load !== 1'b1 && t < 8) begin tick(); t++; end
    n_cmp++; if (lfsr_load !== 1'b1 || lfsr_seed !== 6'h01) begin n_fail++; $display("FAIL mid_reload: load=%b seed=%h want 1/01", lfsr_load, lfsr_seed); end
    m_seed  = W'(1);
    m_steps = 0;
    ticks(3);
    step_run(2);
  endtask

  initial begin
    test_reset();
    test_step_period();
    test_random_steps();
    test_run();
    test_run_rate();
    test_lockup();
    test_lockup_run();
    test_glitch_and_simul();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
